// File: rtl/jk_excitation_seq.sv
// jk_excitation_seq: sequencer for a bank of JK flip-flops.
// Holds a small table of target state words, and for each step derives the J/K
// excitation that moves the tracked present state Q onto the next target.
// Each J/K pair is offered on a valid/ready port, and Q mirrors the bank once
// the step is accepted.
module jk_excitation_seq #(
  parameter int              WIDTH   = 4,
  parameter int              DEPTH   = 8,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}},
  parameter bit              DC_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic             loop,
  input  logic             stop,
  output logic [WIDTH-1:0] J_out,
  output logic [WIDTH-1:0] K_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    count_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             loop_r;
  logic [WIDTH-1:0] table_mem [DEPTH];
  logic [WIDTH-1:0] tgt_s;
  logic [WIDTH-1:0] next_q_s;
  logic             run_s;
  logic             hs_s;
  logic             last_s;
  logic             wr_fire_s;
  logic             start_ok_s;

  // J excitation: don't-cares (q=1) become DC_FILL.
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
    if (DC_FILL) return t | q;
    else         return ~q & t;
  endfunction

  // K excitation: don't-cares (q=0) become DC_FILL.
  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
    if (DC_FILL) return ~(q & t);
    else         return q & ~t;
  endfunction

  // JK characteristic equation applied to the whole bank.
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k,
                                               input logic [WIDTH-1:0] q);
    return (j & ~q) | (~k & q);
  endfunction

  assign run_s      = (state_r == S_RUN);
  assign hs_s       = run_s & out_ready;
  assign tgt_s      = table_mem[rd_ptr_r];
  assign last_s     = ({1'b0, rd_ptr_r} == (count_r - CW'(1)));
  assign wr_fire_s  = wr_en & wr_ready & ~Clear;
  assign start_ok_s = (state_r == S_IDLE) & start & (count_r != {CW{1'b0}});
  assign next_q_s   = jk_next(J_out, K_out, Q);

  // State register; Clear returns to IDLE.
  always_ff @(posedge clk) begin
    if (Clear) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic: a run ends on stop, or after the last entry when not looping.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) state_nxt_s = S_RUN;
        else            state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (stop)                        state_nxt_s = S_DONE;
        else if (hs_s && last_s && !loop_r) state_nxt_s = S_DONE;
        else                             state_nxt_s = S_RUN;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State-decoded handshake flags; writes are only taken in IDLE with room left.
  always_comb begin
    out_valid = 1'b0;
    done      = 1'b0;
    wr_ready  = 1'b0;
    case (state_r)
      S_IDLE:  wr_ready  = (count_r < CW'(DEPTH));
      S_RUN:   out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: wr_ready  = 1'b0;
    endcase
  end

  // Excitation for the current step, zero outside RUN.
  always_comb begin
    J_out = {WIDTH{1'b0}};
    K_out = {WIDTH{1'b0}};
    if (run_s) begin
      J_out = exc_j(Q, tgt_s);
      K_out = exc_k(Q, tgt_s);
    end else begin
      J_out = {WIDTH{1'b0}};
      K_out = {WIDTH{1'b0}};
    end
  end

  // Target table storage; contents are not reset, count alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_fire_s) table_mem[count_r[AW-1:0]] <= wr_data;
  end

  // Table count, read pointer, loop flag, tracked state and error pulse.
  always_ff @(posedge clk) begin
    if (Clear) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      loop_r   <= 1'b0;
      Q        <= INIT;
      err      <= 1'b0;
    end else begin
      // Start is judged on the pre-write count, so an empty table plus a
      // simultaneous write still reports an error.
      err <= (wr_en & ~wr_ready) |
             ((state_r == S_IDLE) & start & (count_r == {CW{1'b0}}));
      if (wr_fire_s) count_r <= count_r + CW'(1);
      if (start_ok_s) begin
        rd_ptr_r <= {AW{1'b0}};
        loop_r   <= loop;
      end
      if (hs_s) begin
        Q <= next_q_s;
        if (last_s) rd_ptr_r <= {AW{1'b0}};
        else        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_excitation_seq.sv
// Self-checking bench for jk_excitation_seq: two instances share stimulus, one
// with DC_FILL=0 and one with DC_FILL=1. Expected steps are queued when a run is
// launched and popped by a monitor on every accepted handshake.
module tb_jk_excitation_seq;

  logic       clk;
  logic       clr;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       start;
  logic       loop;
  logic       stop;
  logic       out_ready;
  logic [3:0] j0, k0, q0, j1, k1, q1;
  logic       wrr0, wrr1, ov0, ov1, done0, done1, err0, err1;

  jk_excitation_seq #(.WIDTH(4), .DEPTH(8), .INIT(4'b0000), .DC_FILL(1'b0)) u_dut0 (
    .clk(clk), .Clear(clr), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wrr0),
    .start(start), .loop(loop), .stop(stop), .J_out(j0), .K_out(k0),
    .out_valid(ov0), .out_ready(out_ready), .Q(q0), .done(done0), .err(err0));

  jk_excitation_seq #(.WIDTH(4), .DEPTH(8), .INIT(4'b0000), .DC_FILL(1'b1)) u_dut1 (
    .clk(clk), .Clear(clr), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wrr1),
    .start(start), .loop(loop), .stop(stop), .J_out(j1), .K_out(k1),
    .out_valid(ov1), .out_ready(out_ready), .Q(q1), .done(done1), .err(err1));

  typedef struct {
    logic [3:0] j0, k0, j1, k1, q;
  } exp_t;

  typedef struct {
    logic [3:0] wr;
    logic [3:0] j0, k0, j1, k1;
  } vec_t;

  exp_t       sb[$];
  logic [3:0] mtab[$];
  logic [3:0] model_q;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         hs_count = 0;
  int         cyc      = 0;
  int         last_hs_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time the done pulse against the last handshake.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference excitation straight from the per-bit excitation table.
  function automatic logic [7:0] ref_jk(input logic [3:0] q, input logic [3:0] t, input logic dc);
    logic [3:0] j, k;
    for (int i = 0; i < 4; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin j[i] = 1'b0; k[i] = dc;   end
        2'b01:   begin j[i] = 1'b1; k[i] = dc;   end
        2'b10:   begin j[i] = dc;   k[i] = 1'b1; end
        default: begin j[i] = dc;   k[i] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  task automatic push_run(input int n);
    int idx;
    exp_t e;
    logic [7:0] a, b;
    idx = 0;
    for (int s = 0; s < n; s++) begin
      a = ref_jk(model_q, mtab[idx], 1'b0);
      b = ref_jk(model_q, mtab[idx], 1'b1);
      e.j0 = a[7:4]; e.k0 = a[3:0]; e.j1 = b[7:4]; e.k1 = b[3:0]; e.q = model_q;
      sb.push_back(e);
      model_q = mtab[idx];
      idx = (idx + 1) % mtab.size();
    end
  endtask

  // Scoreboard monitor: every accepted step is compared with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!clr && ov0 === 1'b1 && out_ready) begin
      hs_count++;
      last_hs_cyc = cyc;
      check("ov_match", ov1, 1'b1);
      if (sb.size() == 0) begin
        check("sb_unexpected_step", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("step_j0", j0, e.j0);
        check("step_k0", k0, e.k0);
        check("step_j1", j1, e.j1);
        check("step_k1", k1, e.k1);
        check("step_q0", q0, e.q);
        check("step_q1", q1, e.q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_done0"}, done0, 1'b1);
    check({name, "_done1"}, done1, 1'b1);
    check({name, "_done_lat"}, cyc, last_hs_cyc + 1);
    check({name, "_q0_final"}, q0, model_q);
    check({name, "_q1_final"}, q1, model_q);
    tick();
    check({name, "_done_pulse"}, done0, 1'b0);
    check({name, "_ov_after"}, ov0, 1'b0);
  endtask

  vec_t vt[3];

  initial begin
    logic [3:0] prev;
    int n, base;
    exp_t e;

    vt[0] = '{wr: 4'b0101, j0: 4'b0101, k0: 4'b0000, j1: 4'b0101, k1: 4'b1111};
    vt[1] = '{wr: 4'b0011, j0: 4'b0010, k0: 4'b0100, j1: 4'b0111, k1: 4'b1110};
    vt[2] = '{wr: 4'b1100, j0: 4'b1100, k0: 4'b0011, j1: 4'b1111, k1: 4'b1111};

    clr = 1'b1; wr_en = 1'b0; wr_data = 4'b0000; start = 1'b0; loop = 1'b0;
    stop = 1'b0; out_ready = 1'b0;
    model_q = 4'b0000;
    tick(); tick();
    clr = 1'b0;
    check("rst_ov", ov0, 1'b0);
    check("rst_j", j0, 4'b0000);
    check("rst_k", k0, 4'b0000);
    check("rst_q", q0, 4'b0000);
    check("rst_wr_ready", wrr0, 1'b1);
    check("rst_done", done0, 1'b0);
    check("rst_err", err0, 1'b0);

    // T1/T2: table-driven three-step run on both fill policies.
    prev = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check("t1_wr_ready", wrr0, 1'b1);
      write(vt[i].wr);
      e.j0 = vt[i].j0; e.k0 = vt[i].k0; e.j1 = vt[i].j1; e.k1 = vt[i].k1; e.q = prev;
      sb.push_back(e);
      mtab.push_back(vt[i].wr);
      prev = vt[i].wr;
    end
    model_q = prev;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t1");

    // T3: replay from current Q with a three-cycle stall after the first step.
    out_ready = 1'b0;
    push_run(3);
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_ov_held", ov0, 1'b1);
      check("t3_j_held", j0, sb[0].j0);
      check("t3_k_held", k0, sb[0].k0);
      check("t3_q_held", q0, sb[0].q);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t3");

    // T6: Clear during a run.
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("t6_ov_pre", ov0, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t6_ov", ov0, 1'b0);
    check("t6_q", q0, 4'b0000);
    check("t6_wr_ready", wrr0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_done", done0, 1'b0);
      tick();
    end
    model_q = 4'b0000;
    mtab.delete();

    // T4: looping run ended by stop together with an accepted step.
    write(4'b0001); mtab.push_back(4'b0001);
    write(4'b0010); mtab.push_back(4'b0010);
    push_run(5);
    base = hs_count;
    out_ready = 1'b1;
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0; loop = 1'b0;
    tick();
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    check("t4_err_busy", err0, 1'b1);
    n = 0;
    while (hs_count - base < 4 && n < 40) begin
      tick();
      n++;
    end
    check("t4_reach4", hs_count - base, 4);
    stop = 1'b1;
    wait_done("t4");
    stop = 1'b0;
    check("t4_steps", hs_count - base, 5);

    // T5: empty start, simultaneous write+start, full table.
    clr = 1'b1; tick(); clr = 1'b0;
    model_q = 4'b0000;
    mtab.delete();
    start = 1'b1; tick(); start = 1'b0;
    check("t5_err_empty", err0, 1'b1);
    check("t5_ov_empty", ov0, 1'b0);
    tick();
    check("t5_err_one", err0, 1'b0);
    wr_en = 1'b1; start = 1'b1; wr_data = 4'b1001; tick(); wr_en = 1'b0; start = 1'b0;
    mtab.push_back(4'b1001);
    check("t5_err_both", err0, 1'b1);
    check("t5_ov_both", ov0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      check("t5_wr_ready", wrr0, 1'b1);
      write(4'((i * 3) % 16));
      mtab.push_back(4'((i * 3) % 16));
    end
    check("t5_full", wrr0, 1'b0);
    write(4'b1111);
    check("t5_err_full", err0, 1'b1);
    push_run(8);
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t5");

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
